i2c_eeprom_slave: RTL and testbench
===================================

Name: i2c_eeprom_slave

Overview:
- I2C target that emulates a 24Cxx-style serial EEPROM (device address 7'b1010_000) with 256 bytes of internal storage.
- Gives on-chip, self-checking loopback for the team's EEPROM I2C master.
- Supports byte write, sequential write, random read via repeated START, and sequential read.
- Exposes a write-observation strobe so benches and debug logic can see committed bytes.

Parameters:
- DEV_ADDR, 7'b1010000, 7-bit target address matched against the first byte after START.
- ADDR_W, 8, word-address and pointer width; memory depth is 2**ADDR_W bytes.
- HOLD_CYC, 8, clk cycles after a detected SCL falling edge before SDA is updated. Must be less than the master's SCL low time (80 cycles at 50 MHz/400 kHz).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- SCL  input  1  I2C clock from master
- SDA  inout  1  I2C data, open-drain: driven 0 or released to 1'bz, never driven 1
- oWrValid  output  1  one-cycle pulse when a received data byte is committed to memory
- oWrAddr  output  ADDR_W  address of the committed byte, valid with oWrValid
- oWrData  output  8  committed byte, valid with oWrValid
- oBusy  output  1  high from an addressed START (address match) until STOP or return to IDLE

Behaviour:
- Reset (async, rst=1):
  - SDA released; all outputs 0; state IDLE; pointer 0; bit counter 0.
  - Memory contents are not reset.
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer plus one history flop.
  - scl_rise/scl_fall are one-cycle pulses from the synced samples.
- START: synced SDA 1->0 while synced SCL is high in both the current and previous sample.
- STOP: synced SDA 0->1 under the same condition.
  - SDA and SCL edges arriving in the same cycle (the master changes both at once) must not produce START/STOP.
- START in any state: bit counter cleared, SDA released, go to DEV_ADDR (covers repeated START).
- STOP in any state: SDA released, go to IDLE, oBusy=0.
- Data sampling: SDA is sampled on scl_rise, MSB first.
- Data driving: SDA changes only HOLD_CYC cycles after scl_fall.
- States:
  - IDLE: ignore the bus until START.
  - DEV_ADDR: shift 8 bits.
    - Bits[7:1]==DEV_ADDR -> ACK, oBusy=1.
    - R/W=0 -> WORD_ADDR; R/W=1 -> RD_DATA.
    - Mismatch -> no ACK, go to IDLE.
  - ACK slot (shared by all ACKing states): SDA driven low HOLD_CYC after the 8th bit's scl_fall; released HOLD_CYC after the following scl_fall.
  - WORD_ADDR: shift 8 bits, load pointer (low ADDR_W bits), ACK, then WR_DATA.
  - WR_DATA: shift 8 bits.
    - On the 8th scl_rise: mem[ptr] <= byte; oWrValid pulses the next cycle with oWrAddr=ptr, oWrData=byte.
    - ptr <= ptr+1, wrapping (2**ADDR_W-1) -> 0.
    - ACK; repeat WR_DATA until START or STOP.
  - RD_DATA:
    - The shift register is loaded with mem[ptr] at the end of the preceding ACK slot; ptr <= ptr+1 (wrap).
    - The MSB is driven at that slot's release point; later bits are driven HOLD_CYC after each scl_fall. A 1 bit = released, a 0 bit = driven low.
  - RD_ACK:
    - SDA released; master ACK/NACK sampled on scl_rise.
    - 0 -> reload and continue RD_DATA.
    - 1 (NACK) -> go to IDLE and wait for STOP/START.
- Bit counter is 3 bits; the 8th bit is counter==7.
- Reset mid-transfer: immediate release of SDA; the bus is re-acquired only on the next START.

Optional Feature:
- Macro: I2C_SLAVE_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample stability filter follows the synchronizer on SCL and SDA.
  - The filtered value changes only after 3 consecutive equal samples; pulses shorter than 3 clk are suppressed.
  - Adds 2 cycles of edge latency.
- Undefined: synchronizer only.

Test Plan:
- Byte write: master writes idata=8'h5A to iAddr=8'h10. Required: ACK on all three bytes; oWrValid single pulse with oWrAddr=8'h10, oWrData=8'h5A; oBusy falls on STOP; master oDone pulses.
- Random read: after the above, master reads iAddr=8'h10. Required: ACK on 0xA0, 0x10, 0xA1; master odata=8'h5A; master NACK accepted; oBusy=0 after STOP.
- Address mismatch: bench sends START + 8'hA2 + clocks. Required: SDA stays released in the ACK slot; no oWrValid; oBusy stays 0; the master under iCall[1] retries from START.
- Pointer wrap: sequential write of 8'h11, 8'h22 starting at 8'hFF. Required: oWrAddr 8'hFF then 8'h00; a subsequent read of 8'h00 returns 8'h22.
- Mid-transfer reset/START:
  - Assert rst during WR_DATA bit 4: SDA releases within 1 cycle; no oWrValid.
  - Repeated START during WR_DATA: returns to DEV_ADDR with no memory write.
- Glitch (macro defined): 2-cycle low pulse on SCL during a data bit. Required: bit count unchanged; byte received correctly. Macro undefined: documents the expected corruption.

Source files
------------

// File: rtl/i2c_eeprom_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_eeprom_slave_if                                           |
// | Purpose  : Bus bundle for the I2C EEPROM target. It carries SCL from the |
// |            master and the write-observation / busy outputs.              |
// |            SDA is open-drain, so it stays a plain inout on the target.   |
// | Signals  : SCL      - I2C clock from master                              |
// |            oWrValid - one-cycle pulse when a byte is committed           |
// |            oWrAddr  - address of the committed byte                      |
// |            oWrData  - committed byte                                     |
// |            oBusy    - target addressed and transfer in progress          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface i2c_eeprom_slave_if #(
    parameter int ADDR_W = 8
);
    logic              SCL;
    logic              oWrValid;
    logic [ADDR_W-1:0] oWrAddr;
    logic [7:0]        oWrData;
    logic              oBusy;

    modport slave  (input  SCL, output oWrValid, oWrAddr, oWrData, oBusy);
    modport master (output SCL, input  oWrValid, oWrAddr, oWrData, oBusy);
endinterface
`default_nettype wire

// File: rtl/i2c_eeprom_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_eeprom_slave                                              |
// | Purpose  : I2C target emulating a 24Cxx-style EEPROM with 2**ADDR_W      |
// |            bytes. Byte/sequential write, random read via repeated       |
// |            START, and sequential read. Committed bytes are reported on  |
// |            a write-observation strobe.                                   |
// | Ports    : clk  - system clock                                           |
// |            rst  - asynchronous active-high reset                         |
// |            bus  - slave modport: SCL in; oWrValid/oWrAddr/oWrData/oBusy  |
// |            SDA  - open-drain data line (driven 0 or released)            |
// | Options  : I2C_SLAVE_GLITCH_FILTER_EN - adds a 3-sample stability filter |
// |            on SCL and SDA after the synchronizer (+2 cycles edge latency)|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR = 7'b1010000,
    parameter int         ADDR_W   = 8,
    parameter int         HOLD_CYC = 8
) (
    input  wire               clk,
    input  wire               rst,
    i2c_eeprom_slave_if.slave bus,
    inout  wire               SDA
);

    localparam int c_HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_DEV     = 3'd1;
    localparam logic [2:0] c_ST_WADDR   = 3'd2;
    localparam logic [2:0] c_ST_WDATA   = 3'd3;
    localparam logic [2:0] c_ST_ACK_DRV = 3'd4;  // waiting to pull SDA low
    localparam logic [2:0] c_ST_ACK_REL = 3'd5;  // waiting to release / drive MSB
    localparam logic [2:0] c_ST_RDATA   = 3'd6;
    localparam logic [2:0] c_ST_RACK    = 3'd7;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
    logic r_scl_prev, r_sda_prev;
    logic w_scl, w_sda;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Idle bus level, so leaving reset does not fake an edge
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_scl_meta <= bus.SCL;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= SDA;
            r_sda_sync <= r_sda_meta;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // The filtered level follows the synced input only once the current
    // sample and the two before it agree; shorter pulses never get through.
    logic [1:0] r_scl_hist, r_sda_hist;
    logic       r_scl_filt, r_sda_filt;

    always_comb begin
        w_scl = r_scl_filt;
        w_sda = r_sda_filt;
        if ({r_scl_hist, r_scl_sync} == 3'b111) w_scl = 1'b1;
        if ({r_scl_hist, r_scl_sync} == 3'b000) w_scl = 1'b0;
        if ({r_sda_hist, r_sda_sync} == 3'b111) w_sda = 1'b1;
        if ({r_sda_hist, r_sda_sync} == 3'b000) w_sda = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync};
            r_scl_filt <= w_scl;
            r_sda_filt <= w_sda;
        end
    end
`else
    assign w_scl = r_scl_sync;
    assign w_sda = r_sda_sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // SCL must be high in both samples, so an SDA edge landing together
    // with an SCL edge is never mistaken for START/STOP.
    assign w_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
    assign w_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

    // ------------------------------------------------------------------
    // SDA update timer: fires once, HOLD_CYC cycles after each SCL fall
    // ------------------------------------------------------------------
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_hold_act;
    logic                w_sda_upd;

    assign w_sda_upd = r_hold_act && (r_hold_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_act <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_scl_fall) begin
            r_hold_act <= 1'b1;
            r_hold_cnt <= c_HOLD_W'(HOLD_CYC - 1);
        end else if (w_sda_upd) begin
            r_hold_act <= 1'b0;
        end else if (r_hold_act) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage and datapath registers
    // ------------------------------------------------------------------
    logic [7:0]        r_mem [0:(2**ADDR_W)-1];
    logic [2:0]        r_state, w_state_nxt;
    logic [2:0]        r_ack_ret, w_ack_ret_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              r_sda_low, w_sda_low_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_mem_we;
    logic              r_wr_valid;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;
    logic       w_last_bit;
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_rd_byte  = r_mem[r_ptr];
    assign w_last_bit = w_scl_rise && (r_cnt == 3'd7);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_ST_DEV;
        end else if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    w_state_nxt = c_ST_IDLE;
                c_ST_DEV: begin
                    if (w_last_bit)
                        w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? c_ST_ACK_DRV : c_ST_IDLE;
                end
                c_ST_WADDR,
                c_ST_WDATA:   if (w_last_bit) w_state_nxt = c_ST_ACK_DRV;
                c_ST_ACK_DRV: if (w_sda_upd)  w_state_nxt = c_ST_ACK_REL;
                c_ST_ACK_REL: if (w_sda_upd)  w_state_nxt = r_ack_ret;
                c_ST_RDATA:   if (w_last_bit) w_state_nxt = c_ST_RACK;
                // Master NACK ends the read; ACK re-enters the release point,
                // which reloads the shift register and drives the next MSB.
                c_ST_RACK:    if (w_scl_rise) w_state_nxt = w_sda ? c_ST_IDLE : c_ST_ACK_REL;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Output / datapath next-value logic
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_low_nxt = r_sda_low;
        w_busy_nxt    = r_busy;
        w_ack_ret_nxt = r_ack_ret;
        w_mem_we      = 1'b0;
        if (w_start) begin
            w_cnt_nxt     = 3'd0;
            w_sda_low_nxt = 1'b0;
        end else if (w_stop) begin
            w_sda_low_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_ST_DEV: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_busy_nxt    = (w_byte[7:1] == DEV_ADDR);
                            w_ack_ret_nxt = w_byte[0] ? c_ST_RDATA : c_ST_WADDR;
                        end
                    end
                end
                c_ST_WADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_ptr_nxt     = ADDR_W'(w_byte);
                            w_ack_ret_nxt = c_ST_WDATA;
                        end
                    end
                end
                c_ST_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_mem_we      = 1'b1;
                            w_ptr_nxt     = r_ptr + 1'b1;
                            w_ack_ret_nxt = c_ST_WDATA;
                        end
                    end
                end
                c_ST_ACK_DRV: if (w_sda_upd) w_sda_low_nxt = 1'b1;
                c_ST_ACK_REL: begin
                    if (w_sda_upd) begin
                        if (r_ack_ret == c_ST_RDATA) begin
                            // MSB goes out now; the rest waits pre-shifted so
                            // bit [7] is always the next bit to drive.
                            w_sda_low_nxt = ~w_rd_byte[7];
                            w_shift_nxt   = {w_rd_byte[6:0], 1'b0};
                            w_ptr_nxt     = r_ptr + 1'b1;
                        end else begin
                            w_sda_low_nxt = 1'b0;
                        end
                    end
                end
                c_ST_RDATA: begin
                    if (w_scl_rise) w_cnt_nxt = r_cnt + 3'd1;
                    if (w_sda_upd) begin
                        w_sda_low_nxt = ~r_shift[7];
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                    end
                end
                c_ST_RACK: begin
                    if (w_sda_upd) w_sda_low_nxt = 1'b0;
                    if (w_scl_rise && w_sda) w_busy_nxt = 1'b0;
                end
                default: w_busy_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 3'd0;
            r_shift    <= 8'd0;
            r_ptr      <= '0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_ack_ret  <= c_ST_IDLE;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'd0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sda_low  <= w_sda_low_nxt;
            r_busy     <= w_busy_nxt;
            r_ack_ret  <= w_ack_ret_nxt;
            r_wr_valid <= w_mem_we;
            if (w_mem_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte;
            end
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_ptr] <= w_byte;
    end

    assign SDA          = r_sda_low ? 1'b0 : 1'bz;
    assign bus.oWrValid = r_wr_valid;
    assign bus.oWrAddr  = r_wr_addr;
    assign bus.oWrData  = r_wr_data;
    assign bus.oBusy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_i2c_eeprom_slave                                           |
// | Purpose  : Randomized self-checking bench for i2c_eeprom_slave. The      |
// |            bench acts as the I2C master and keeps a byte-array EEPROM    |
// |            model with a wrapping address pointer.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_i2c_eeprom_slave;

    localparam int T_LOW  = 30;   // SCL low time in clk
    localparam int T_SET  = 16;   // master data change point within low time
    localparam int T_HIGH = 20;   // SCL high time in clk
    localparam int T_SAMP = 10;   // master sample point within high time

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sda_drv_low = 1'b0;
    wire  sda;

    assign sda = sda_drv_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_eeprom_slave_if #(.ADDR_W(8)) bus ();

    i2c_eeprom_slave #(
        .DEV_ADDR (7'b1010000),
        .ADDR_W   (8),
        .HOLD_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .SDA (sda)
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [7:0]  ref_mem   [256];
    bit          ref_valid [256];
    logic [7:0]  ref_ptr = 8'd0;
    logic [15:0] exp_wr_q[$];
    logic [15:0] got_wr_q[$];
    logic [7:0]  wdata_q[$];

    int n_total = 0;
    int n_bad   = 0;

    always @(negedge clk) begin
        if (bus.oWrValid) got_wr_q.push_back({bus.oWrAddr, bus.oWrData});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Bit-level master (all changes on negedge clk)
    // ------------------------------------------------------------------
    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (bus.SCL == 1'b0) begin
            wclk(T_SET);
            sda_drv_low = 1'b0;
            wclk(T_LOW - T_SET);
            bus.SCL = 1'b1;
        end
        wclk(T_HIGH);
        sda_drv_low = 1'b1;
        wclk(T_HIGH);
        bus.SCL = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(T_SET);
        sda_drv_low = 1'b1;
        wclk(T_LOW - T_SET);
        bus.SCL = 1'b1;
        wclk(T_HIGH);
        sda_drv_low = 1'b0;
        wclk(T_HIGH);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        wclk(T_SET);
        sda_drv_low = ~b;
        wclk(T_LOW - T_SET);
        bus.SCL = 1'b1;
        if (glitch) begin
            wclk(T_SAMP / 2);
            bus.SCL = 1'b0;
            wclk(2);
            bus.SCL = 1'b1;
            wclk(T_HIGH - T_SAMP / 2 - 2);
        end else begin
            wclk(T_HIGH);
        end
        bus.SCL = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        wclk(T_SET);
        sda_drv_low = 1'b0;
        wclk(T_LOW - T_SET);
        bus.SCL = 1'b1;
        wclk(T_SAMP);
        b = sda;
        wclk(T_HIGH - T_SAMP);
        bus.SCL = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
        get_bit(ack_n);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic check_wr_log(input string tag);
        chk({tag, "_wrcount"}, got_wr_q.size(), exp_wr_q.size());
        while (got_wr_q.size() > 0 && exp_wr_q.size() > 0)
            chk({tag, "_wrentry"}, got_wr_q.pop_front(), exp_wr_q.pop_front());
        got_wr_q.delete();
        exp_wr_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Transaction-level operations
    // ------------------------------------------------------------------
    task automatic do_write(input logic [7:0] a, input string tag);
        logic ack_n;
        i2c_start();
        send_byte(8'hA0, ack_n);
        chk({tag, "_devack"}, ack_n, 1'b0);
        chk({tag, "_busy"}, bus.oBusy, 1'b1);
        send_byte(a, ack_n);
        chk({tag, "_addrack"}, ack_n, 1'b0);
        ref_ptr = a;
        foreach (wdata_q[i]) begin
            send_byte(wdata_q[i], ack_n);
            chk({tag, "_dataack"}, ack_n, 1'b0);
            ref_mem[ref_ptr]   = wdata_q[i];
            ref_valid[ref_ptr] = 1'b1;
            exp_wr_q.push_back({ref_ptr, wdata_q[i]});
            ref_ptr = ref_ptr + 8'd1;
        end
        i2c_stop();
        chk({tag, "_busy_after_stop"}, bus.oBusy, 1'b0);
        check_wr_log(tag);
    endtask

    task automatic do_read(input logic [7:0] a, input bit set_addr, input int n, input string tag);
        logic       ack_n;
        logic [7:0] d;
        i2c_start();
        if (set_addr) begin
            send_byte(8'hA0, ack_n);
            chk({tag, "_devack_w"}, ack_n, 1'b0);
            send_byte(a, ack_n);
            chk({tag, "_addrack"}, ack_n, 1'b0);
            ref_ptr = a;
            i2c_start();
        end
        send_byte(8'hA1, ack_n);
        chk({tag, "_devack_r"}, ack_n, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, (i == n - 1));
            if (ref_valid[ref_ptr]) chk({tag, "_data"}, d, ref_mem[ref_ptr]);
            ref_ptr = ref_ptr + 8'd1;
        end
        i2c_stop();
        chk({tag, "_busy_after_stop"}, bus.oBusy, 1'b0);
        check_wr_log(tag);
    endtask

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin
        logic       ack_n;
        logic [7:0] a;
        int         len;

        bus.SCL = 1'b1;
        wclk(5);
        chk("rst_sda", sda, 1'b1);
        chk("rst_busy", bus.oBusy, 1'b0);
        chk("rst_wrvalid", bus.oWrValid, 1'b0);
        chk("rst_wraddr", bus.oWrAddr, 8'h00);
        chk("rst_wrdata", bus.oWrData, 8'h00);
        rst = 1'b0;
        wclk(10);

        // Byte write and random read
        wdata_q = {8'h5A};
        do_write(8'h10, "bytewr");
        do_read(8'h10, 1'b1, 1, "rndrd");

        // Address mismatch: no ACK, bus ignored until next START
        i2c_start();
        send_byte(8'hA2, ack_n);
        chk("mismatch_ack", ack_n, 1'b1);
        chk("mismatch_busy", bus.oBusy, 1'b0);
        send_byte(8'h33, ack_n);
        chk("mismatch_ack2", ack_n, 1'b1);
        i2c_stop();
        check_wr_log("mismatch");

        // Pointer wrap
        wdata_q = {8'h11, 8'h22};
        do_write(8'hFF, "wrap");
        do_read(8'h00, 1'b1, 1, "wrap_rd0");
        do_read(8'hFF, 1'b1, 2, "wrap_seqrd");

        // Randomized writes, current-address reads and sequential reads
        for (int k = 0; k < 5; k++) begin
            a   = 8'($urandom);
            len = $urandom_range(1, 3);
            wdata_q.delete();
            for (int j = 0; j < len; j++) wdata_q.push_back(8'($urandom));
            do_write(a, "rnd_wr");
            do_read(8'h00, 1'b0, 2, "rnd_cur");
            do_read(a, 1'b1, len, "rnd_rd");
        end

        // Reset while the target drives its ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0);
        sda_drv_low = 1'b0;
        wclk(T_SET);
        chk("ackslot_driven", sda, 1'b0);
        rst = 1'b1;
        wclk(1);
        chk("ackslot_rst_release", sda, 1'b1);
        chk("ackslot_rst_busy", bus.oBusy, 1'b0);
        rst = 1'b0;
        i2c_stop();

        // Reset during data bit 4 of a write
        wdata_q = {8'h3C};
        do_write(8'h20, "pre20");
        i2c_start();
        send_byte(8'hA0, ack_n);
        send_byte(8'h20, ack_n);
        for (int i = 7; i >= 4; i--) send_bit(((8'hC3 >> i) & 8'h01) != 0, 1'b0);
        wclk(5);
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
        sda_drv_low = 1'b0;
        wclk(2);
        chk("midrst_sda", sda, 1'b1);
        chk("midrst_busy", bus.oBusy, 1'b0);
        i2c_stop();
        check_wr_log("midrst");
        do_read(8'h20, 1'b1, 1, "midrst_rd");

        // Repeated START inside a data byte: no write, pointer unchanged
        i2c_start();
        send_byte(8'hA0, ack_n);
        send_byte(8'h20, ack_n);
        ref_ptr = 8'h20;
        for (int i = 7; i >= 4; i--) send_bit(1'b1, 1'b0);
        do_read(8'h00, 1'b0, 1, "repstart");

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // Short SCL low pulse during a data bit must be filtered out
        i2c_start();
        send_byte(8'hA0, ack_n);
        send_byte(8'h30, ack_n);
        for (int i = 7; i >= 0; i--) send_bit(((8'h96 >> i) & 8'h01) != 0, (i == 3));
        get_bit(ack_n);
        chk("glitch_ack", ack_n, 1'b0);
        i2c_stop();
        ref_mem[8'h30]   = 8'h96;
        ref_valid[8'h30] = 1'b1;
        exp_wr_q.push_back({8'h30, 8'h96});
        check_wr_log("glitch");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
